// File: rtl/kalman_spi_scheduler.sv
// Round-robin scheduler sharing one SPI result shifter between NUM_CH filter channels.
// Optional KALMAN_SCHED_OVERWRITE_EN: newest sample overwrites a pending one, counted in o_overrun_cnt.
module kalman_spi_scheduler #(
    parameter int NUM_CH        = 3,
    parameter int DATA_W        = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STROBE_CYCLES = 2,
    localparam int CW           = $clog2(NUM_CH),
    localparam int SW           = $clog2(STROBE_CYCLES + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CH-1:0]        i_ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
    output logic [NUM_CH-1:0]        o_ch_ready,
    input  logic                     i_rpi_cs,
    output logic [DATA_W-1:0]        o_out_data,
    output logic                     o_out_done,
    output logic [CW-1:0]            o_grant_ch,
`ifdef KALMAN_SCHED_OVERWRITE_EN
    output logic [7:0]               o_overrun_cnt,
`endif
    output logic                     o_busy
);

    localparam int IW = CW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARMED, S_XFER} state_t;

    state_t                         r_state, w_state_nx;
    logic [SYNC_STAGES-1:0]         r_sync;
    logic                           w_cs_s;
    logic [NUM_CH-1:0][DATA_W-1:0]  r_hold;
    logic [NUM_CH-1:0]              r_pend;
    logic [NUM_CH-1:0]              w_cap;
    logic [NUM_CH-1:0]              w_clr;
    logic [CW-1:0]                  r_rr;
    logic [CW-1:0]                  w_win;
    logic                           w_found;
    logic [IW-1:0]                  w_idx;
    logic [SW-1:0]                  r_cnt;
    logic                           w_grant;
    logic                           w_cnt_inc;
    logic                           w_busy_clr;
    logic                           w_done;
    logic [DATA_W-1:0]              r_out_data;
    logic [CW-1:0]                  r_grant_ch;
    logic                           r_busy;

    // rpi_cs is asynchronous; only the synchronized copy feeds decisions
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= '1;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_rpi_cs};
    end
    assign w_cs_s = r_sync[SYNC_STAGES-1];

`ifdef KALMAN_SCHED_OVERWRITE_EN
    logic [NUM_CH-1:0] w_ovr;
    logic [3:0]        w_ovr_n;
    logic [8:0]        w_ovr_sum;
    logic [7:0]        r_ovr;

    assign w_cap      = i_ch_valid;
    assign o_ch_ready = '1;
    assign w_ovr      = i_ch_valid & r_pend;

    always_comb begin
        w_ovr_n = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (w_ovr[i]) w_ovr_n = w_ovr_n + 4'd1;
        w_ovr_sum = {1'b0, r_ovr} + {5'b0, w_ovr_n};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)             r_ovr <= '0;
        else if (w_ovr_sum[8]) r_ovr <= 8'hFF;
        else                   r_ovr <= w_ovr_sum[7:0];
    end
    assign o_overrun_cnt = r_ovr;
`else
    assign w_cap      = i_ch_valid & ~r_pend;
    assign o_ch_ready = ~r_pend;
`endif

    // Set beats clear so an overwrite coinciding with a grant stays pending
    assign w_clr = {{(NUM_CH-1){1'b0}}, w_grant} << w_win;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= '0;
            r_hold <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (w_cap[i]) r_hold[i] <= i_ch_data[i*DATA_W +: DATA_W];
            r_pend <= (r_pend & ~w_clr) | w_cap;
        end
    end

    // Search starts one past the last winner and wraps
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = IW'(r_rr) + IW'(k);
            if (w_idx >= IW'(NUM_CH)) w_idx = w_idx - IW'(NUM_CH);
            if (!w_found && r_pend[w_idx[CW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[CW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_cnt_inc  = 1'b0;
        w_busy_clr = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && w_cs_s) begin
                    w_grant    = 1'b1;
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                // A falling cs_s kills the strobe in the same cycle
                if (!w_cs_s) begin
                    w_state_nx = S_XFER;
                end else begin
                    w_done = 1'b1;
                    if (r_cnt == SW'(STROBE_CYCLES - 1)) w_state_nx = S_ARMED;
                    else                                 w_cnt_inc  = 1'b1;
                end
            end
            S_ARMED: begin
                if (!w_cs_s) w_state_nx = S_XFER;
            end
            S_XFER: begin
                if (w_cs_s) begin
                    w_busy_clr = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_data <= '0;
            r_grant_ch <= '0;
            r_busy     <= 1'b0;
            r_rr       <= CW'(NUM_CH - 1);
            r_cnt      <= '0;
        end else if (w_grant) begin
            r_out_data <= r_hold[w_win];
            r_grant_ch <= w_win;
            r_busy     <= 1'b1;
            r_rr       <= w_win;
            r_cnt      <= '0;
        end else begin
            if (w_cnt_inc)  r_cnt  <= r_cnt + 1'b1;
            if (w_busy_clr) r_busy <= 1'b0;
        end
    end

    assign o_out_data = r_out_data;
    assign o_out_done = w_done;
    assign o_grant_ch = r_grant_ch;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_kalman_spi_scheduler.sv
// Directed bench for kalman_spi_scheduler (NUM_CH=3, DATA_W=16, SYNC_STAGES=2, STROBE_CYCLES=2).
module tb_kalman_spi_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ch_valid = '0;
    logic [47:0] ch_data = '0;
    logic [2:0]  ch_ready;
    logic        rpi_cs = 1'b1;
    logic [15:0] out_data;
    logic        out_done;
    logic [1:0]  grant_ch;
    logic        busy;
`ifdef KALMAN_SCHED_OVERWRITE_EN
    logic [7:0]  overrun_cnt;
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    kalman_spi_scheduler #(
        .NUM_CH(3), .DATA_W(16), .SYNC_STAGES(2), .STROBE_CYCLES(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_ch_valid(ch_valid),
        .i_ch_data(ch_data),
        .o_ch_ready(ch_ready),
        .i_rpi_cs(rpi_cs),
        .o_out_data(out_data),
        .o_out_done(out_done),
        .o_grant_ch(grant_ch),
`ifdef KALMAN_SCHED_OVERWRITE_EN
        .o_overrun_cnt(overrun_cnt),
`endif
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_ready(input logic [2:0] pend);
        return OVW ? 3'b111 : ~pend;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ch_valid = '0;
        rpi_cs = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Checks one complete load, then runs a 16-cycle cs-low transaction
    task automatic serve(input int ch, input logic [15:0] d);
        chk("serve_done1", out_done, 1'b1);
        chk("serve_data", out_data, d);
        chk("serve_grant", grant_ch, ch);
        chk("serve_busy", busy, 1'b1);
        step(1);
        chk("serve_done2", out_done, 1'b1);
        step(1);
        chk("serve_done_end", out_done, 1'b0);
        rpi_cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("no_done_cs_low", out_done, 1'b0);
        end
        rpi_cs = 1'b1;
        step(3);
        chk("serve_busy_clr", busy, 1'b0);
        step(1);
    endtask

    initial begin
        // reset values
        do_reset();
        chk("rst_data", out_data, 16'h0);
        chk("rst_done", out_done, 1'b0);
        chk("rst_grant", grant_ch, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ch_ready, 3'b111);
`ifdef KALMAN_SCHED_OVERWRITE_EN
        chk("rst_ovr", overrun_cnt, 8'd0);
`endif

        // single load latency
        ch_data[15:0] = 16'h1234;
        ch_valid = 3'b001;
        step(1);
        ch_valid = '0;
        chk("t1_ready_pend", ch_ready, exp_ready(3'b001));
        chk("t1_done_early", out_done, 1'b0);
        step(1);
        chk("t1_done1", out_done, 1'b1);
        chk("t1_data", out_data, 16'h1234);
        chk("t1_grant", grant_ch, 2'd0);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready_free", ch_ready, 3'b111);
        step(1);
        chk("t1_done2", out_done, 1'b1);
        step(1);
        chk("t1_done_off", out_done, 1'b0);
        chk("t1_busy_armed", busy, 1'b1);
        rpi_cs = 1'b0;
        step(3);
        chk("t1_busy_xfer", busy, 1'b1);
        rpi_cs = 1'b1;
        step(3);
        chk("t1_busy_end", busy, 1'b0);
        chk("t1_data_hold", out_data, 16'h1234);

        // three simultaneous requests served 0,1,2
        do_reset();
        ch_data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        ch_valid = 3'b111;
        step(1);
        ch_valid = '0;
        chk("t2_ready", ch_ready, exp_ready(3'b111));
        step(1);
        serve(0, 16'hAAAA);
        serve(1, 16'hBBBB);
        serve(2, 16'hCCCC);
        chk("t2_idle_done", out_done, 1'b0);
        chk("t2_idle_busy", busy, 1'b0);

        // request while cs held low
        do_reset();
        rpi_cs = 1'b0;
        step(3);
        ch_data[31:16] = 16'h5555;
        ch_valid = 3'b010;
        step(1);
        ch_valid = '0;
        chk("t3_ready", ch_ready, exp_ready(3'b010));
        chk("t3_done", out_done, 1'b0);
        chk("t3_busy", busy, 1'b0);
        step(4);
        chk("t3_done_wait", out_done, 1'b0);
        chk("t3_busy_wait", busy, 1'b0);
        rpi_cs = 1'b1;
        step(1);
        chk("t3_done_c1", out_done, 1'b0);
        step(1);
        chk("t3_done_c2", out_done, 1'b0);
        step(1);
        chk("t3_done_c3", out_done, 1'b1);
        chk("t3_data", out_data, 16'h5555);
        chk("t3_grant", grant_ch, 2'd1);
        step(2);
        chk("t3_done_off", out_done, 1'b0);

        // cs falls during the strobe
        do_reset();
        ch_data[15:0] = 16'h0F0F;
        ch_valid = 3'b001;
        step(1);
        ch_valid = '0;
        rpi_cs = 1'b0;
        step(1);
        chk("t4_done1", out_done, 1'b1);
        chk("t4_data", out_data, 16'h0F0F);
        step(1);
        chk("t4_done_drop", out_done, 1'b0);
        chk("t4_busy", busy, 1'b1);
        step(1);
        chk("t4_done_xfer", out_done, 1'b0);
        rpi_cs = 1'b1;
        step(2);
        chk("t4_busy_xfer", busy, 1'b1);
        step(1);
        chk("t4_busy_end", busy, 1'b0);
        chk("t4_done_end", out_done, 1'b0);

        // reset during XFER with ch2 pending
        do_reset();
        ch_data = {16'h2222, 16'h0000, 16'h1111};
        ch_valid = 3'b101;
        step(1);
        ch_valid = '0;
        step(3);
        rpi_cs = 1'b0;
        step(3);
        chk("t5_busy_xfer", busy, 1'b1);
        chk("t5_ready_pend", ch_ready, exp_ready(3'b100));
        chk("t5_data", out_data, 16'h1111);
        rst = 1'b1;
        rpi_cs = 1'b1;
        step(1);
        chk("t5_rst_data", out_data, 16'h0);
        chk("t5_rst_done", out_done, 1'b0);
        chk("t5_rst_grant", grant_ch, 2'd0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ready", ch_ready, 3'b111);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("t5_no_stale_done", out_done, 1'b0);
            chk("t5_no_stale_busy", busy, 1'b0);
        end

        // repeated valids on one channel while cs is low
        do_reset();
        rpi_cs = 1'b0;
        step(3);
        ch_valid = 3'b001;
        ch_data[15:0] = 16'h0001;
        step(1);
        ch_data[15:0] = 16'h0002;
        step(1);
        ch_data[15:0] = 16'h0003;
        step(1);
        ch_valid = '0;
        chk("t6_ready", ch_ready, exp_ready(3'b001));
`ifdef KALMAN_SCHED_OVERWRITE_EN
        chk("t6_overrun", overrun_cnt, 8'd2);
`endif
        rpi_cs = 1'b1;
        step(3);
        chk("t6_done", out_done, 1'b1);
        chk("t6_data", out_data, OVW ? 16'h0003 : 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
